// File: rtl/conv_mac_core.sv
// conv_mac_core: 2-D convolution MAC stage with SAME zero padding.
// Holds KERNEL_NUM square kernels loaded over a serial weight port and turns
// one FMS_PATCH_SIZE x FMS_PATCH_SIZE patch per handshake into one
// full-precision sum per output pixel per kernel.
// Two-stage pipeline: stage 1 registers every product, stage 2 registers the
// reduced sums that drive conv_data.
// Optional feature macro: CONV_MAC_RELU_EN (clamp negative sums to 0).
module conv_mac_core #(
   parameter int FMS_PATCH_SIZE    = 4,
   parameter int INFMS_DATA_WIDTH  = 8,
   parameter int KERNEL_DATA_WIDTH = 8,
   parameter int KERNEL_SIZE       = 3,
   parameter int KERNEL_NUM        = 2,
   localparam int PROD_W = INFMS_DATA_WIDTH + KERNEL_DATA_WIDTH,
   localparam int SUM_W  = PROD_W + $clog2(KERNEL_SIZE * KERNEL_SIZE)
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    clk_en,
   input  logic                                    kernel_wr_vld,
   output logic                                    kernel_wr_rdy,
   input  logic [KERNEL_DATA_WIDTH-1:0]            kernel_wr_data,
   output logic                                    kernel_loaded,
   input  logic                                    infms_data_vld,
   output logic                                    infms_data_rdy,
   input  logic [INFMS_DATA_WIDTH*FMS_PATCH_SIZE*FMS_PATCH_SIZE-1:0] infms_data,
   output logic                                    conv_data_vld,
   input  logic                                    conv_data_rdy,
   output logic [SUM_W*KERNEL_NUM*FMS_PATCH_SIZE*FMS_PATCH_SIZE-1:0] conv_data
);

   localparam int P     = FMS_PATCH_SIZE;
   localparam int IW    = INFMS_DATA_WIDTH;
   localparam int KS    = KERNEL_SIZE;
   localparam int KN    = KERNEL_NUM;
   localparam int KSQ   = KS * KS;
   localparam int PAD   = KS / 2;
   localparam int NW    = KN * KSQ;
   localparam int NOUT  = KN * P * P;
   localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;

   typedef enum logic {
      ST_LOAD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t                             state_r;
   logic [CNT_W-1:0]                   load_cnt_r;
   logic signed [KERNEL_DATA_WIDTH-1:0] weight_r [NW];
   logic                               kernel_loaded_r;

   logic                               s1_vld_r;
   logic signed [PROD_W-1:0]           prod_r [NOUT*KSQ];
   logic                               conv_vld_r;
   logic signed [SUM_W-1:0]            sum_r [NOUT];

   logic signed [PROD_W-1:0]           prod_s [NOUT*KSQ];
   logic signed [SUM_W-1:0]            sum_s [NOUT];
   logic [CNT_W-1:0]                   wr_idx_s;
   logic                               s2_free_s;
   logic                               s1_adv_s;
   logic                               s1_free_s;
   logic                               pipe_empty_s;
   logic                               wr_fire_s;
   logic                               in_fire_s;

   // Handshake plumbing: a stage may take new data when it is empty or draining.
   assign s2_free_s      = !conv_vld_r || conv_data_rdy;
   assign s1_adv_s       = s1_vld_r && s2_free_s;
   assign s1_free_s      = !s1_vld_r || s1_adv_s;
   assign pipe_empty_s   = !s1_vld_r && !conv_vld_r;
   // Patches win over weight words in RUN; a reload waits for an empty pipeline.
   assign kernel_wr_rdy  = clk_en && ((state_r == ST_LOAD) || (pipe_empty_s && !infms_data_vld));
   assign infms_data_rdy = clk_en && (state_r == ST_RUN) && s1_free_s;
   assign wr_fire_s      = kernel_wr_vld && kernel_wr_rdy;
   assign in_fire_s      = infms_data_vld && infms_data_rdy;
   assign kernel_loaded  = kernel_loaded_r;
   assign conv_data_vld  = conv_vld_r;

   // Select the weight slot for an incoming word: a word arriving in RUN restarts at 0.
   always_comb begin
      wr_idx_s = '0;
      case (state_r)
         ST_LOAD: wr_idx_s = load_cnt_r;
         ST_RUN:  wr_idx_s = '0;
         default: wr_idx_s = '0;
      endcase
   end

   // Load/run control with weight storage; the last word of a full set enters RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r         <= ST_LOAD;
         load_cnt_r      <= '0;
         kernel_loaded_r <= 1'b0;
         for (int i = 0; i < NW; i++) begin
            weight_r[i] <= '0;
         end
      end else if (wr_fire_s) begin
         weight_r[wr_idx_s] <= kernel_wr_data;
         if (wr_idx_s == CNT_W'(NW - 1)) begin
            state_r         <= ST_RUN;
            load_cnt_r      <= '0;
            kernel_loaded_r <= 1'b1;
         end else begin
            state_r         <= ST_LOAD;
            load_cnt_r      <= wr_idx_s + CNT_W'(1);
            kernel_loaded_r <= 1'b0;
         end
      end
   end

   // Form every padded pixel x tap product for all kernels and output pixels.
   always_comb begin
      for (int i = 0; i < NOUT * KSQ; i++) begin
         prod_s[i] = '0;
      end
      for (int k = 0; k < KN; k++) begin
         for (int h = 0; h < P; h++) begin
            for (int w = 0; w < P; w++) begin
               for (int r = 0; r < KS; r++) begin
                  for (int c = 0; c < KS; c++) begin
                     int hh;
                     int ww;
                     logic signed [IW-1:0] pix_v;
                     hh = h + r - PAD;
                     ww = w + c - PAD;
                     if (hh >= 0 && hh < P && ww >= 0 && ww < P) begin
                        pix_v = infms_data[(hh*P + ww)*IW +: IW];
                     end else begin
                        pix_v = '0;
                     end
                     prod_s[((k*P + h)*P + w)*KSQ + r*KS + c] =
                        PROD_W'(pix_v) * PROD_W'(weight_r[k*KSQ + r*KS + c]);
                  end
               end
            end
         end
      end
   end

   // Reduce each tap set to one sign-extended sum, optionally rectified.
   always_comb begin
      for (int o = 0; o < NOUT; o++) begin
         logic signed [SUM_W-1:0] acc_v;
         acc_v = '0;
         for (int t = 0; t < KSQ; t++) begin
            acc_v = acc_v + SUM_W'(prod_r[o*KSQ + t]);
         end
`ifdef CONV_MAC_RELU_EN
         if (acc_v[SUM_W-1]) begin
            sum_s[o] = '0;
         end else begin
            sum_s[o] = acc_v;
         end
`else
         sum_s[o] = acc_v;
`endif
      end
   end

   // Stage 1: capture products of an accepted patch; hold while stage 2 is blocked.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld_r <= 1'b0;
         for (int i = 0; i < NOUT * KSQ; i++) begin
            prod_r[i] <= '0;
         end
      end else if (clk_en) begin
         if (s1_free_s) begin
            s1_vld_r <= in_fire_s;
         end
         if (in_fire_s) begin
            prod_r <= prod_s;
         end
      end
   end

   // Stage 2: capture sums when the output slot is empty or being consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         conv_vld_r <= 1'b0;
         for (int o = 0; o < NOUT; o++) begin
            sum_r[o] <= '0;
         end
      end else if (clk_en) begin
         if (s2_free_s) begin
            conv_vld_r <= s1_vld_r;
            if (s1_vld_r) begin
               sum_r <= sum_s;
            end
         end
      end
   end

   // Pack the result registers into the kernel-major output bus.
   always_comb begin
      conv_data = '0;
      for (int o = 0; o < NOUT; o++) begin
         conv_data[o*SUM_W +: SUM_W] = sum_r[o];
      end
   end

endmodule

// File: tb/tb_conv_mac_core.sv
// Self-checking bench for conv_mac_core: directed scenarios with hand-computed
// values, then randomized traffic, all checked against a behavioural model.
module tb_conv_mac_core;

   localparam int P     = 4;
   localparam int IW    = 8;
   localparam int KW    = 8;
   localparam int KS    = 3;
   localparam int KN    = 2;
   localparam int KSQ   = KS * KS;
   localparam int NW    = KN * KSQ;
   localparam int PAD   = KS / 2;
   localparam int SUM_W = IW + KW + $clog2(KSQ);
   localparam int INW   = IW * P * P;
   localparam int OUTW  = SUM_W * KN * P * P;
`ifdef CONV_MAC_RELU_EN
   localparam int K1_NEG5 = 0;
`else
   localparam int K1_NEG5 = -5;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic            clk_en;
   logic            kernel_wr_vld;
   logic            kernel_wr_rdy;
   logic [KW-1:0]   kernel_wr_data;
   logic            kernel_loaded;
   logic            infms_data_vld;
   logic            infms_data_rdy;
   logic [INW-1:0]  infms_data;
   logic            conv_data_vld;
   logic            conv_data_rdy;
   logic [OUTW-1:0] conv_data;

   int checks = 0;
   int errors = 0;

   // behavioural model state
   int              w_m [NW];
   int              cnt_m = 0;
   bit              loaded_m = 1'b0;
   logic [OUTW-1:0] exp_q [$];
   int              age_q [$];

   conv_mac_core dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
      .kernel_wr_vld(kernel_wr_vld), .kernel_wr_rdy(kernel_wr_rdy),
      .kernel_wr_data(kernel_wr_data), .kernel_loaded(kernel_loaded),
      .infms_data_vld(infms_data_vld), .infms_data_rdy(infms_data_rdy),
      .infms_data(infms_data), .conv_data_vld(conv_data_vld),
      .conv_data_rdy(conv_data_rdy), .conv_data(conv_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [OUTW-1:0] act, input logic [OUTW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Plain convolution with zero padding using the model's weights.
   function automatic logic [OUTW-1:0] model_conv(input logic [INW-1:0] pix);
      logic [OUTW-1:0] v;
      logic signed [IW-1:0] b;
      logic [31:0] sv;
      int s;
      v = '0;
      for (int k = 0; k < KN; k++)
         for (int h = 0; h < P; h++)
            for (int w = 0; w < P; w++) begin
               s = 0;
               for (int r = 0; r < KS; r++)
                  for (int c = 0; c < KS; c++) begin
                     int hh;
                     int ww;
                     hh = h + r - PAD;
                     ww = w + c - PAD;
                     if (hh >= 0 && hh < P && ww >= 0 && ww < P) begin
                        b = pix[(hh*P + ww)*IW +: IW];
                        s += int'(b) * w_m[k*KSQ + r*KS + c];
                     end
                  end
`ifdef CONV_MAC_RELU_EN
               if (s < 0) s = 0;
`endif
               sv = s;
               v[((k*P + h)*P + w)*SUM_W +: SUM_W] = sv[SUM_W-1:0];
            end
      return v;
   endfunction

   function automatic int get(input logic [OUTW-1:0] d, input int k, input int h, input int w);
      logic signed [SUM_W-1:0] x;
      x = d[((k*P + h)*P + w)*SUM_W +: SUM_W];
      return int'(x);
   endfunction

   function automatic logic [INW-1:0] rand_patch();
      logic [INW-1:0] v;
      for (int i = 0; i < INW / 32; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   // Compare process: outputs are checked every falling edge, then the model
   // absorbs the handshakes that the next rising edge will perform.
   always @(negedge clk) begin : monitor
      bit exp_wr_rdy;
      bit exp_in_rdy;
      bit exp_vld;
      if (!rst_n) begin
         exp_q.delete();
         age_q.delete();
         cnt_m = 0;
         loaded_m = 1'b0;
         for (int i = 0; i < NW; i++) w_m[i] = 0;
         check("rst_conv_data", conv_data, '0);
      end
      exp_vld    = (exp_q.size() > 0) && (age_q[0] >= 2);
      exp_wr_rdy = clk_en && (!loaded_m || (exp_q.size() == 0 && !infms_data_vld));
      exp_in_rdy = clk_en && loaded_m && (exp_q.size() < 2 || conv_data_rdy);
      check("kernel_loaded", OUTW'(kernel_loaded), OUTW'(loaded_m));
      check("kernel_wr_rdy", OUTW'(kernel_wr_rdy), OUTW'(exp_wr_rdy));
      check("infms_data_rdy", OUTW'(infms_data_rdy), OUTW'(exp_in_rdy));
      check("conv_data_vld", OUTW'(conv_data_vld), OUTW'(exp_vld));
      if (exp_vld) check("conv_data", conv_data, exp_q[0]);
      if (rst_n) begin
         if (clk_en && exp_vld && conv_data_rdy) begin
            void'(exp_q.pop_front());
            void'(age_q.pop_front());
         end
         if (clk_en) foreach (age_q[i]) age_q[i]++;
         if (infms_data_vld && exp_in_rdy) begin
            exp_q.push_back(model_conv(infms_data));
            age_q.push_back(1);
         end
         if (kernel_wr_vld && exp_wr_rdy) begin
            int idx;
            logic signed [KW-1:0] wb;
            idx = loaded_m ? 0 : cnt_m;
            wb = kernel_wr_data;
            w_m[idx] = int'(wb);
            if (idx == NW - 1) begin
               loaded_m = 1'b1;
               cnt_m = 0;
            end else begin
               loaded_m = 1'b0;
               cnt_m = idx + 1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic send_word(input logic [KW-1:0] d);
      bit done;
      done = 1'b0;
      kernel_wr_data = d;
      kernel_wr_vld = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (kernel_wr_rdy) done = 1'b1;
         tick();
      end
      kernel_wr_vld = 1'b0;
      check("word_accept", OUTW'(done), OUTW'(1'b1));
   endtask

   task automatic send_patch(input logic [INW-1:0] d);
      bit done;
      done = 1'b0;
      infms_data = d;
      infms_data_vld = 1'b1;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (infms_data_rdy) done = 1'b1;
         tick();
      end
      infms_data_vld = 1'b0;
      check("patch_accept", OUTW'(done), OUTW'(1'b1));
   endtask

   // Send a patch into an empty pipeline; returns on the falling edge where the result is visible.
   task automatic send_and_wait(input logic [INW-1:0] d);
      send_patch(d);
      @(negedge clk);
      check("latency_edge1", OUTW'(conv_data_vld), OUTW'(1'b0));
      @(negedge clk);
      check("latency_edge2", OUTW'(conv_data_vld), OUTW'(1'b1));
   endtask

   task automatic load_set(input logic [KW-1:0] wts [NW]);
      for (int i = 0; i < NW; i++) begin
         if (i == NW - 1) infms_data_vld = 1'b0;
         send_word(wts[i]);
         if (i == 0) begin
            @(negedge clk);
            check("loaded_drop", OUTW'(kernel_loaded), OUTW'(1'b0));
            tick();
         end
      end
      @(negedge clk);
      check("loaded_rise", OUTW'(kernel_loaded), OUTW'(1'b1));
      tick();
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      logic [KW-1:0]  wset [NW];
      logic [INW-1:0] pats [3];
      int acc;
      rst_n = 1'b0; clk_en = 1'b1;
      kernel_wr_vld = 1'b0; kernel_wr_data = '0;
      infms_data_vld = 1'b0; infms_data = '0; conv_data_rdy = 1'b1;
      @(negedge clk);
      check("rst_wr_rdy", OUTW'(kernel_wr_rdy), OUTW'(1'b1));
      check("rst_in_rdy", OUTW'(infms_data_rdy), OUTW'(1'b0));
      check("rst_vld", OUTW'(conv_data_vld), OUTW'(1'b0));
      tick();
      rst_n = 1'b1;
      tick();

      // kernel 0 all ones, kernel 1 centre tap only
      for (int i = 0; i < NW; i++) wset[i] = (i < KSQ || i == KSQ + 4) ? 8'h01 : 8'h00;
      load_set(wset);
      send_and_wait({16{8'h01}});
      check("k0_corner", OUTW'(get(conv_data, 0, 0, 0)), OUTW'(4));
      check("k0_edge", OUTW'(get(conv_data, 0, 0, 1)), OUTW'(6));
      check("k0_interior", OUTW'(get(conv_data, 0, 1, 1)), OUTW'(9));
      check("k1_corner", OUTW'(get(conv_data, 1, 3, 3)), OUTW'(1));
      check("k1_interior", OUTW'(get(conv_data, 1, 2, 1)), OUTW'(1));
      tick();

      // kernel 0 all -128, kernel 1 centre -1
      for (int i = 0; i < NW; i++) wset[i] = (i < KSQ) ? 8'h80 : ((i == KSQ + 4) ? 8'hFF : 8'h00);
      load_set(wset);
      send_and_wait({16{8'h80}});
      check("neg_interior", OUTW'(get(conv_data, 0, 1, 1)), OUTW'(147456));
      check("neg_corner", OUTW'(get(conv_data, 0, 3, 0)), OUTW'(65536));
      check("neg_k1", OUTW'(get(conv_data, 1, 0, 0)), OUTW'(128));
      tick();
      send_and_wait({16{8'h05}});
      check("relu_k1", OUTW'(get(conv_data, 1, 1, 2)), OUTW'(K1_NEG5));
      tick();

      // backpressure: three patches offered, only two fit
      for (int i = 0; i < 3; i++) pats[i] = rand_patch();
      conv_data_rdy = 1'b0;
      acc = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         infms_data = pats[acc];
         infms_data_vld = 1'b1;
         @(negedge clk);
         if (infms_data_rdy && acc < 2) acc++;
         tick();
      end
      check("bp_accepted", OUTW'(acc), OUTW'(2));
      @(negedge clk);
      check("bp_in_rdy_low", OUTW'(infms_data_rdy), OUTW'(1'b0));
      tick();
      infms_data_vld = 1'b0;
      kernel_wr_vld = 1'b1;
      kernel_wr_data = 8'h02;
      for (int cyc = 0; cyc < 3; cyc++) begin
         @(negedge clk);
         check("wr_blocked", OUTW'(kernel_wr_rdy), OUTW'(1'b0));
         tick();
      end
      kernel_wr_vld = 1'b0;
      conv_data_rdy = 1'b1;
      send_patch(pats[2]);
      repeat (4) tick();
      for (int i = 0; i < NW; i++) wset[i] = 8'(i * 7 - 60);
      load_set(wset);
      send_and_wait(rand_patch());
      tick();

      // async reset after 7 words: a full reload is required
      for (int i = 0; i < 7; i++) send_word(8'(i + 3));
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      infms_data = {16{8'h05}};
      infms_data_vld = 1'b1;
      repeat (3) tick();
      for (int i = 0; i < NW; i++) wset[i] = (i < KSQ) ? 8'h01 : ((i == KSQ + 4) ? 8'hFF : 8'h00);
      load_set(wset);
      send_and_wait({16{8'h05}});
      check("reload_k0", OUTW'(get(conv_data, 0, 1, 1)), OUTW'(45));
      check("reload_k0_corner", OUTW'(get(conv_data, 0, 0, 3)), OUTW'(20));
      check("reload_k1", OUTW'(get(conv_data, 1, 1, 1)), OUTW'(K1_NEG5));
      tick();

      // randomized traffic with clock-enable gaps, reloads and one reset
      for (int cyc = 0; cyc < 2000; cyc++) begin
         clk_en = ($urandom_range(0, 7) != 0);
         conv_data_rdy = ($urandom_range(0, 3) != 0);
         infms_data_vld = ($urandom_range(0, 1) == 1);
         infms_data = rand_patch();
         kernel_wr_vld = kernel_loaded ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 3) != 0);
         kernel_wr_data = 8'($urandom);
         rst_n = (cyc != 1200);
         tick();
      end
      clk_en = 1'b1; conv_data_rdy = 1'b1; rst_n = 1'b1;
      infms_data_vld = 1'b0; kernel_wr_vld = 1'b0;
      repeat (8) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
